mvm_cmd_sequencer: RTL and testbench
====================================

// Module: mvm_cmd_sequencer
// PURPOSE
//  Command/sequencing controller for the UART matrix-vector multiply datapath.
//  - Parses the received UART byte stream into load/compute commands.
//  - Writes matrix and vector elements into the external operand store.
//  - Steps the MAC unit row by row and streams each result back to the UART transmitter.
//  - Sits between uart_rx/uart_tx and the operand RAM + MAC inside the top level.
// PARAMETERS
//  N      4   matrix dimension (NxN matrix, N-element vector); power of 2, 2..16
//  DW     8   signed element width
//  ACC_W  18  MAC accumulator width, >= 2*DW+$clog2(N)
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           async active-low reset
//  rx_data    in   8           received byte
//  rx_valid   in   1           1-cycle strobe, rx_data valid
//  tx_data    out  8           byte to transmit
//  tx_valid   out  1           tx byte offered; held with tx_data stable until tx_ready
//  tx_ready   in   1           transmitter accepts when tx_valid&&tx_ready
//  wr_en      out  1           operand store write strobe
//  wr_sel     out  1           0=matrix, 1=vector
//  wr_addr    out  log2(N*N)   element index (row-major for matrix)
//  wr_data    out  DW          element value (= rx_data[DW-1:0])
//  mat_raddr  out  log2(N*N)   matrix read address; store has 1-cycle sync read
//  vec_raddr  out  log2(N)     vector read address
//  mac_clr    out  1           clear accumulator (1-cycle pulse)
//  mac_en     out  1           accumulate current store outputs this cycle
//  acc_in     in   ACC_W       signed accumulator value from MAC
//  busy       out  1           high in any state other than IDLE
//  rx_drop    out  1           1-cycle pulse: rx byte discarded (busy or unknown cmd)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. The operand store is not cleared.
//  Reset mid-operation aborts immediately; partially sent results are not resumed.
//  Commands (byte received in IDLE):
//  - 0xA0 -> LOAD_M: next N*N bytes written to matrix, addr 0..N*N-1.
//  - 0xB0 -> LOAD_V: next N bytes written to vector, addr 0..N-1.
//  - 0xC0 -> compute. Any other byte: rx_drop, remain in IDLE.
//  Load: wr_en asserted on the cycle after each rx_valid; wr_addr/wr_data registered.
//    Returns to IDLE on the cycle the last write is issued; busy stays high until then.
//  Compute FSM: CLR -> RD -> DRAIN -> CAP -> TX_HI -> TX_LO, repeated for row r=0..N-1, then IDLE.
//  - CLR: mac_clr=1 for 1 cycle; c=0.
//  - RD: mat_raddr=r*N+c, vec_raddr=c for c=0..N-1 (N cycles).
//    mac_en is asserted 1 cycle after each address (read latency), so exactly N mac_en pulses per row.
//  - DRAIN: 1 cycle for the last mac_en.
//  - CAP: latch acc_in into a 16-bit result register (see CONFIGURATION).
//  - TX_HI/TX_LO: send result[15:8] then result[7:0].
//    Each byte is held until the tx handshake completes; state advances on handshake.
//    After TX_LO, go to CLR for r+1, or to IDLE when r==N-1.
//  Row latency without backpressure: 1+N+1+1 cycles before tx_valid rises.
//  rx_valid while busy outside LOAD states: byte discarded, rx_drop pulses.
//    This includes rx during compute.
//  rx_valid and tx handshake in the same cycle: both honoured independently.
//  Row/column counters wrap only via the FSM; no address ever exceeds N*N-1.
// CONFIGURATION
//  MVM_SAT_EN defined:
//  - acc_in is saturated to signed 16-bit range [-32768, 32767] in CAP.
//  MVM_SAT_EN undefined:
//  - result = acc_in[15:0] (two's-complement wrap); no saturation logic is present.
// TESTING
//  Bench uses a behavioural 1-cycle-read operand RAM and a MAC model.
//  1. Identity matrix, vector {1,2,3,4}, 0xC0 -> tx bytes 00 01 00 02 00 03 00 04; busy falls after the last byte.
//  2. Matrix all 0x7F, vector all 0x7F -> per row 0x7FFF with MVM_SAT_EN, 0xFC04 without.
//  3. Matrix all 0x80, vector all 0x7F -> 0x8000 with MVM_SAT_EN, 0x0200 without.
//  4. tx_ready held low 20 cycles during TX_HI -> tx_data/tx_valid stable; no byte lost or duplicated; exactly N mac_en per row.
//  5. Byte 0x55 in IDLE, and any byte during compute -> rx_drop pulse, state and outputs unchanged.
//  6. rst_n low after 5 of 16 matrix bytes -> outputs 0 and IDLE.
//     Then a fresh 0xA0 load writes from addr 0.

Source files
------------

// File: rtl/mvm_cmd_sequencer.sv
// mvm_cmd_sequencer
//   Command/sequencing controller for the UART matrix-vector multiply datapath.
//   Parses the received byte stream into load/compute commands, writes matrix and
//   vector elements into the external operand store, steps the MAC unit row by row
//   and streams each 16-bit row result back to the UART transmitter (high byte first).
//
//   Commands (byte received while idle):
//     0xA0  load matrix: next N*N bytes, row-major, addr 0..N*N-1
//     0xB0  load vector: next N bytes, addr 0..N-1
//     0xC0  compute all N rows and transmit the results
//     other bytes are discarded with an rx_drop pulse
//
// Parameters
//   N      matrix dimension, power of 2 in 2..16
//   DW     signed element width
//   ACC_W  MAC accumulator width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     received byte and its 1-cycle strobe
//   tx_data, tx_valid     byte offered to the transmitter, held until tx_ready
//   tx_ready              transmitter accepts on tx_valid && tx_ready
//   wr_en/sel/addr/data   operand store write port (sel 0 = matrix, 1 = vector)
//   mat_raddr, vec_raddr  operand store read addresses (1-cycle synchronous read)
//   mac_clr, mac_en       accumulator clear pulse / accumulate enable
//   acc_in                signed accumulator value from the MAC
//   busy                  high in any state other than idle
//   rx_drop               1-cycle pulse when a received byte is discarded
//
// Build option
//   MVM_SAT_EN  when defined, acc_in is saturated to the signed 16-bit range on
//               capture; otherwise the low 16 bits are taken (two's-complement wrap).
module mvm_cmd_sequencer #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         wr_en,
  output logic                         wr_sel,
  output logic [$clog2(N*N)-1:0]       wr_addr,
  output logic [DW-1:0]                wr_data,
  output logic [$clog2(N*N)-1:0]       mat_raddr,
  output logic [$clog2(N)-1:0]         vec_raddr,
  output logic                         mac_clr,
  output logic                         mac_en,
  input  logic [ACC_W-1:0]             acc_in,
  output logic                         busy,
  output logic                         rx_drop
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned AW = $clog2(N*N);

  localparam logic [7:0] CmdLoadM   = 8'hA0;
  localparam logic [7:0] CmdLoadV   = 8'hB0;
  localparam logic [7:0] CmdCompute = 8'hC0;

  localparam logic [AW-1:0] LastM   = AW'(N*N-1);
  localparam logic [AW-1:0] LastV   = AW'(N-1);
  localparam logic [RW-1:0] LastIdx = RW'(N-1);

  typedef enum logic [3:0] {
    StIdle,
    StLoadM,
    StLoadV,
    StClr,
    StRd,
    StDrain,
    StCap,
    StTxHi,
    StTxLo
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;     // load element index
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   col_q;
  logic [15:0]     result_q;
  logic [15:0]     cap_val;

`ifdef MVM_SAT_EN
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-32768);

  always_comb begin
    cap_val = acc_in[15:0];
    if ($signed(acc_in) > SatMax) begin
      cap_val = 16'h7fff;
    end else if ($signed(acc_in) < SatMin) begin
      cap_val = 16'h8000;
    end
  end
`else
  logic unused_acc_hi;

  assign cap_val       = acc_in[15:0];
  assign unused_acc_hi = ^acc_in[ACC_W-1:16];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      result_q  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      mat_raddr <= '0;
      vec_raddr <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      busy      <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      wr_en   <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      rx_drop <= 1'b0;

      // Bytes arriving during compute are discarded; the FSM is not disturbed.
      if (rx_valid && (state_q != StIdle) && (state_q != StLoadM) && (state_q != StLoadV)) begin
        rx_drop <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            case (rx_data)
              CmdLoadM: begin
                state_q <= StLoadM;
                cnt_q   <= '0;
                busy    <= 1'b1;
              end
              CmdLoadV: begin
                state_q <= StLoadV;
                cnt_q   <= '0;
                busy    <= 1'b1;
              end
              CmdCompute: begin
                state_q <= StClr;
                row_q   <= '0;
                mac_clr <= 1'b1;
                busy    <= 1'b1;
              end
              default: rx_drop <= 1'b1;
            endcase
          end
        end

        StLoadM, StLoadV: begin
          if (rx_valid) begin
            wr_en   <= 1'b1;
            wr_sel  <= (state_q == StLoadV);
            wr_addr <= cnt_q;
            wr_data <= rx_data[DW-1:0];
            cnt_q   <= cnt_q + AW'(1);
            // Leave on the same edge that issues the final write.
            if (cnt_q == ((state_q == StLoadV) ? LastV : LastM)) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end

        StClr: begin
          col_q     <= '0;
          mat_raddr <= {row_q, {RW{1'b0}}};
          vec_raddr <= '0;
          state_q   <= StRd;
        end

        StRd: begin
          // Store data for this address arrives next cycle, so mac_en lags by one.
          mac_en <= 1'b1;
          if (col_q == LastIdx) begin
            state_q <= StDrain;
          end else begin
            col_q     <= col_q + RW'(1);
            // N is a power of two, so {row, col} is row*N + col.
            mat_raddr <= {row_q, col_q + RW'(1)};
            vec_raddr <= col_q + RW'(1);
          end
        end

        StDrain: state_q <= StCap;

        StCap: begin
          result_q <= cap_val;
          tx_data  <= cap_val[15:8];
          tx_valid <= 1'b1;
          state_q  <= StTxHi;
        end

        StTxHi: begin
          if (tx_ready) begin
            tx_data <= result_q[7:0];
            state_q <= StTxLo;
          end
        end

        StTxLo: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (row_q == LastIdx) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              row_q   <= row_q + RW'(1);
              mac_clr <= 1'b1;
              state_q <= StClr;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_cmd_sequencer.sv
// Self-checking bench for mvm_cmd_sequencer. Models a 1-cycle-read operand RAM and
// a MAC; expected tx bytes come from a matrix/vector reference kept in plain ints.
// Honours MVM_SAT_EN the same way as the design.
module tb_mvm_cmd_sequencer;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 18;
  localparam int RW    = $clog2(N);
  localparam int AW    = $clog2(N*N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             wr_en;
  logic             wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [AW-1:0]    mat_raddr;
  logic [RW-1:0]    vec_raddr;
  logic             mac_clr;
  logic             mac_en;
  logic [ACC_W-1:0] acc_in;
  logic             busy;
  logic             rx_drop;

  mvm_cmd_sequencer #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mat_raddr (mat_raddr),
    .vec_raddr (vec_raddr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .acc_in    (acc_in),
    .busy      (busy),
    .rx_drop   (rx_drop)
  );

  always #5 clk = ~clk;

  // Operand store with 1-cycle synchronous read.
  logic signed [DW-1:0] mem_m [N*N];
  logic signed [DW-1:0] mem_v [N];
  logic signed [DW-1:0] rd_m, rd_v;

  always @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) mem_v[wr_addr[RW-1:0]] <= wr_data;
      else        mem_m[wr_addr] <= wr_data;
    end
    rd_m <= mem_m[mat_raddr];
    rd_v <= mem_v[vec_raddr];
  end

  // MAC model.
  logic signed [ACC_W-1:0] acc;
  int prod;
  assign prod   = int'(rd_m) * int'(rd_v);
  assign acc_in = acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + ACC_W'(prod);
  end

  // Reference data and scoreboard state.
  int n_tests = 0;
  int n_fail  = 0;
  int m_ref [N*N];
  int v_ref [N];
  logic [7:0]       exp_tx [$];
  logic [AW+DW:0]   exp_wr [$];
  int drops_seen = 0;
  int drops_exp  = 0;
  int rdy_mode   = 1;  // 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_row(input int r);
    int s = 0;
    for (int c = 0; c < N; c++) s += m_ref[r*N+c] * v_ref[c];
`ifdef MVM_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expectations whenever the DUT presents a write or a tx byte.
  logic       prev_v, prev_hs;
  logic [7:0] prev_d;
  int         mac_cnt, tx_idx;
  logic [7:0]     e_tx;
  logic [AW+DW:0] e_wr;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
      prev_d  = '0;
      mac_cnt = 0;
      tx_idx  = 0;
    end else begin
      if (prev_v && !prev_hs) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, prev_d);
      end
      if (mac_clr) mac_cnt = 0;
      if (mac_en)  mac_cnt++;
      if (tx_valid && tx_ready) begin
        if (tx_idx % 2 == 0) check("mac_en_per_row", mac_cnt, N);
        tx_idx++;
        if (exp_tx.size() == 0) begin
          check("tx_extra_byte", tx_data, 64'hdead);
        end else begin
          e_tx = exp_tx.pop_front();
          check("tx_byte", tx_data, e_tx);
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          check("wr_extra", {wr_sel, wr_addr, wr_data}, 64'hdead);
        end else begin
          e_wr = exp_wr.pop_front();
          check("wr_sel_addr_data", {wr_sel, wr_addr, wr_data}, e_wr);
        end
      end
      if (rx_drop) drops_seen++;
      prev_v  = tx_valid;
      prev_d  = tx_data;
      prev_hs = tx_valid && tx_ready;
    end
  end

  // Stimulus tasks start and end at posedge + #1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic load_elem(input logic sel, input int idx, input logic [7:0] b);
    exp_wr.push_back({sel, AW'(idx), b});
    if (sel) v_ref[idx] = int'($signed(b));
    else     m_ref[idx] = int'($signed(b));
    send_byte(b, $urandom_range(0, 1));
  endtask

  task automatic load_matrix(input int mode, input logic [7:0] fill);
    send_byte(8'hA0, 0);
    for (int i = 0; i < N*N; i++) begin
      if (mode == 0)      load_elem(1'b0, i, (i / N == i % N) ? 8'h01 : 8'h00);
      else if (mode == 1) load_elem(1'b0, i, fill);
      else                load_elem(1'b0, i, 8'($urandom));
    end
  endtask

  task automatic load_vector(input int mode, input logic [7:0] fill);
    send_byte(8'hB0, 0);
    for (int i = 0; i < N; i++) begin
      if (mode == 0)      load_elem(1'b1, i, 8'(i + 1));
      else if (mode == 1) load_elem(1'b1, i, fill);
      else                load_elem(1'b1, i, 8'($urandom));
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (busy && k < bound) begin @(posedge clk); #1; k++; end
    check(name, busy, 0);
  endtask

  task automatic push_res(input logic [15:0] v);
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
  endtask

  // fixed != 0: every row must equal fixed_val (values stated up front).
  task automatic compute(input int fixed, input logic [15:0] fixed_val, input int drop_mid);
    for (int r = 0; r < N; r++) push_res(fixed ? fixed_val : ref_row(r));
    send_byte(8'hC0, 0);
    check("busy_after_cmd", busy, 1);
    if (drop_mid) begin
      @(posedge clk); #1;
      drops_exp++;
      send_byte(8'($urandom), 0);
    end
    wait_idle("busy_after_compute", 2000);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("rx_drop_count", drops_seen, drops_exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_mat_raddr", mat_raddr, 0);
    check("rst_vec_raddr", vec_raddr, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_drop", rx_drop, 0);
  endtask

  initial begin
    logic [15:0] t1 [N];
    int k;
    @(posedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity matrix times {1,2,3,4}.
    load_matrix(0, 8'h00);
    load_vector(0, 8'h00);
    for (int r = 0; r < N; r++) t1[r] = 16'(r + 1);
    for (int r = 0; r < N; r++) push_res(t1[r]);
    send_byte(8'hC0, 0);
    wait_idle("t1_busy_falls", 2000);
    check("t1_queue_drained", exp_tx.size(), 0);

    // Large positive products.
    load_matrix(1, 8'h7F);
    load_vector(1, 8'h7F);
`ifdef MVM_SAT_EN
    compute(1, 16'h7FFF, 0);
`else
    compute(1, 16'hFC04, 0);
`endif

    // Large negative products.
    load_matrix(1, 8'h80);
`ifdef MVM_SAT_EN
    compute(1, 16'h8000, 0);
`else
    compute(1, 16'h0200, 0);
`endif

    // Random operands with random transmitter backpressure.
    rdy_mode = 2;
    for (int t = 0; t < 6; t++) begin
      load_matrix(2, 8'h00);
      load_vector(2, 8'h00);
      compute(0, 16'h0000, 0);
    end

    // Hold tx_ready low for 20 cycles while the first high byte is offered.
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int r = 0; r < N; r++) push_res(ref_row(r));
    send_byte(8'hC0, 0);
    k = 0;
    while (!tx_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("stall_tx_valid_rises", tx_valid, 1);
    repeat (20) begin @(posedge clk); #1; end
    check("stall_tx_valid_held", tx_valid, 1);
    check("stall_tx_data_held", tx_data, exp_tx[0]);
    rdy_mode = 1;
    wait_idle("stall_busy_falls", 2000);
    check("stall_queue_drained", exp_tx.size(), 0);

    // Unknown command in idle, and a byte during compute.
    send_byte(8'h55, 0);
    drops_exp++;
    @(posedge clk); #1;
    check("idle_drop_count", drops_seen, drops_exp);
    check("idle_drop_busy", busy, 0);
    check("idle_drop_no_tx", tx_valid, 0);
    rdy_mode = 2;
    compute(0, 16'h0000, 1);
    rdy_mode = 1;

    // Reset after 5 of 16 matrix bytes, then a fresh load from address 0.
    send_byte(8'hA0, 0);
    for (int i = 0; i < 5; i++) load_elem(1'b0, i, 8'($urandom));
    @(posedge clk); #1;
    check("partial_writes_seen", exp_wr.size(), 0);
    check("partial_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_matrix(2, 8'h00);
    load_vector(2, 8'h00);
    compute(0, 16'h0000, 0);

    check("final_wr_queue_empty", exp_wr.size(), 0);
    check("final_tx_queue_empty", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
